tdm_demux_1x16: RTL and testbench

- Time-division 1-to-16 demultiplexer: the receive end of the 16-slot serial stream produced by the team's 16x1 mux under slot-counter control.
- Takes one bit per valid cycle and steers it into lane slot_cnt of a 16-bit shadow register.
- On the 16th bit, publishes the full frame to a holding register with a valid/ack handshake.
- Sits between the serial link and parallel consumer logic.

---
 rtl/tdm_demux_1x16.sv | 155 +++++++++++++++
 tb/tb_tdm_demux_1x16.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x16.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x16
//
// Receive end of a 16-slot time-division serial stream. Each valid cycle one
// bit is steered into lane slot_cnt (or 15-slot_cnt when MSB_FIRST=1) of a
// shadow register. The last slot of a frame publishes the completed word into
// the dout holding register, with a valid/ack handshake towards the consumer.
//
// Optional build macro: TDM_DEMUX_PARITY_EN
//   Frame grows to 17 slots. Slot 16 carries even parity over slots 0-15.
//   Publish happens on slot 16, slot_cnt widens to 5 bits, and par_err is
//   added (registered at publish, valid while frame_valid=1).
//
// Parameters:
//   OUT_INIT   reset value of dout
//   MSB_FIRST  0: first slot lands in dout[0]; 1: first slot lands in dout[15]
//
// Ports:
//   clk          system clock, all logic on rising edge
//   rst_n        synchronous active-low reset
//   din          serial data bit
//   din_valid    din is a slot bit this cycle
//   sof          start of frame, forces the slot counter to slot 0
//   frame_ack    consumer accepts the published frame
//   dout         last completed frame (registered)
//   frame_valid  dout holds an unacknowledged frame
//   frame_done   one-cycle pulse on each publish
//   slot_cnt     slot index the next valid bit will fill
//   par_err      parity error of the published frame (parity build only)
//   overrun      sticky: a frame was published over an unacknowledged one
// ---------------------------------------------------------------------------
module tdm_demux_1x16 #(
    parameter logic [15:0] OUT_INIT  = 16'h0000,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        sof,
    input  logic        frame_ack,
    output logic [15:0] dout,
    output logic        frame_valid,
    output logic        frame_done,
`ifdef TDM_DEMUX_PARITY_EN
    output logic [4:0]  slot_cnt,
    output logic        par_err,
`else
    output logic [3:0]  slot_cnt,
`endif
    output logic        overrun
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_W    = 5;
    localparam int FRAME_LEN = 17;
`else
    localparam int SLOT_W    = 4;
    localparam int FRAME_LEN = 16;
`endif
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

    logic [SLOT_W-1:0] slot_cnt_reg;
    logic [SLOT_W-1:0] eff_slot;
    logic [3:0]        lane;
    logic [15:0]       lane_sel;
    logic [15:0]       merged;
    logic [15:0]       shadow_reg;
    logic [15:0]       dout_reg;
    logic              frame_valid_reg;
    logic              frame_done_reg;
    logic              overrun_reg;
    logic              store_bit;
    logic              publish;

    // sof with a valid bit means this bit is slot 0, whatever the counter says.
    assign eff_slot = sof ? '0 : slot_cnt_reg;
    assign lane     = MSB_FIRST ? (4'd15 - eff_slot[3:0]) : eff_slot[3:0];

    // One-hot lane decode; merged is the shadow with the incoming bit dropped
    // into its lane, so the last bit can be published without an extra cycle.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign lane_sel[gi] = (lane == 4'(gi));
            assign merged[gi]   = lane_sel[gi] ? din : shadow_reg[gi];
        end
    endgenerate

`ifdef TDM_DEMUX_PARITY_EN
    // Slot 16 is the parity bit and never lands in the shadow.
    assign store_bit = din_valid & ~eff_slot[4];
`else
    assign store_bit = din_valid;
`endif

    assign publish = din_valid & ~sof & (slot_cnt_reg == LAST_SLOT);

`ifdef TDM_DEMUX_PARITY_EN
    logic par_err_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_reg      <= '0;
            slot_cnt_reg    <= '0;
            dout_reg        <= OUT_INIT;
            frame_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            overrun_reg     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_reg     <= 1'b0;
`endif
        end else begin
            frame_done_reg <= 1'b0;

            if (store_bit) begin
                shadow_reg <= merged;
            end

            if (sof) begin
                slot_cnt_reg <= din_valid ? SLOT_W'(1) : '0;
            end else if (din_valid) begin
                slot_cnt_reg <= publish ? '0 : slot_cnt_reg + SLOT_W'(1);
            end

            if (publish) begin
`ifdef TDM_DEMUX_PARITY_EN
                dout_reg    <= shadow_reg;
                par_err_reg <= ^shadow_reg ^ din;
`else
                dout_reg    <= merged;
`endif
                frame_valid_reg <= 1'b1;
                frame_done_reg  <= 1'b1;
                // An ack arriving on the publish cycle releases the old frame,
                // so only an unacknowledged one counts as overrun.
                if (frame_valid_reg && !frame_ack) begin
                    overrun_reg <= 1'b1;
                end
            end else if (frame_ack) begin
                frame_valid_reg <= 1'b0;
            end
        end
    end

    assign dout        = dout_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_done  = frame_done_reg;
    assign slot_cnt    = slot_cnt_reg;
    assign overrun     = overrun_reg;
`ifdef TDM_DEMUX_PARITY_EN
    assign par_err     = par_err_reg;
`endif

endmodule

// File: tb/tb_tdm_demux_1x16.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1x16
//
// Two instances share the same serial stimulus: dut0 (LSB first, default
// reset value) and dut1 (MSB first, OUT_INIT=16'hBEEF). Expected publishes are
// pushed to a scoreboard when the last slot bit is driven and popped by a
// monitor when frame_done is seen. Supports the TDM_DEMUX_PARITY_EN build.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1x16;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SW    = 5;
    localparam int NSLOT = 17;
`else
    localparam int SW    = 4;
    localparam int NSLOT = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic sof = 1'b0;
    logic frame_ack = 1'b0;

    logic [15:0]   dout0, dout1;
    logic          fv0, fv1, fd0, fd1, ov0, ov1;
    logic [SW-1:0] sc0, sc1;
`ifdef TDM_DEMUX_PARITY_EN
    logic          pe0, pe1;
`endif

    always #5 clk = ~clk;

    tdm_demux_1x16 #(.OUT_INIT(16'h0000), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .sof(sof), .frame_ack(frame_ack), .dout(dout0), .frame_valid(fv0),
        .frame_done(fd0), .slot_cnt(sc0),
`ifdef TDM_DEMUX_PARITY_EN
        .par_err(pe0),
`endif
        .overrun(ov0)
    );

    tdm_demux_1x16 #(.OUT_INIT(16'hBEEF), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .sof(sof), .frame_ack(frame_ack), .dout(dout1), .frame_valid(fv1),
        .frame_done(fd1), .slot_cnt(sc1),
`ifdef TDM_DEMUX_PARITY_EN
        .par_err(pe1),
`endif
        .overrun(ov1)
    );

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic        fv;
        logic        ovr;
        logic        perr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          model_fv = 1'b0;
    bit          model_ovr = 1'b0;
    logic [15:0] cur_word = 16'h0000;
    int          frame_no = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] bitrev(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

    // One clock cycle of stimulus. pub marks the cycle whose edge publishes.
    task automatic cyc(input logic v, input logic d, input logic s, input logic a,
                       input bit pub, input bit perr);
        exp_t e;
        din_valid = v;
        din       = d;
        sof       = s;
        frame_ack = a;
        if (pub) begin
            e.d0   = cur_word;
            e.d1   = bitrev(cur_word);
            e.ovr  = model_ovr | (model_fv & ~a);
            e.fv   = 1'b1;
            e.perr = perr;
            sb.push_back(e);
            model_ovr = e.ovr;
            model_fv  = 1'b1;
        end else if (a) begin
            model_fv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom % 2), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        model_fv  = 1'b0;
        model_ovr = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] word, input bit sof_first,
                              input bit ack_last, input int gap_max, input bit bad_par);
        logic b;
        bit   last;
        cur_word = word;
        for (int i = 0; i < NSLOT; i++) begin
            idle($urandom_range(gap_max, 0));
            b    = (i < 16) ? word[i] : (^word ^ bad_par);
            last = (i == NSLOT - 1);
            cyc(1'b1, b, sof_first && (i == 0), ack_last && last, last, bad_par);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_dout0"}, 32'(dout0), 32'h0000);
        check_val({tag, "_dout1"}, 32'(dout1), 32'hBEEF);
        check_val({tag, "_fv"},    32'({fv0, fv1}), 32'h0);
        check_val({tag, "_fd"},    32'({fd0, fd1}), 32'h0);
        check_val({tag, "_slot"},  32'({sc0, sc1}), 32'h0);
        check_val({tag, "_ovr"},   32'({ov0, ov1}), 32'h0);
`ifdef TDM_DEMUX_PARITY_EN
        check_val({tag, "_perr"},  32'({pe0, pe1}), 32'h0);
`endif
    endtask

    // Scoreboard monitor: every frame_done pulse must match a pushed frame.
    always @(negedge clk) begin
        if (fd0 !== 1'b0 || fd1 !== 1'b0) begin
            check_val("done_pair", 32'({fd0, fd1}), 32'h3);
            if (sb.size() == 0) begin
                check_val("spurious_publish", 32'(sb.size()), 32'h1);
            end else begin
                mon_e = sb.pop_front();
                frame_no++;
                check_val("pub_dout0", 32'(dout0), 32'(mon_e.d0));
                check_val("pub_dout1", 32'(dout1), 32'(mon_e.d1));
                check_val("pub_fv",    32'({fv0, fv1}), {30'h0, mon_e.fv, mon_e.fv});
                check_val("pub_ovr",   32'({ov0, ov1}), {30'h0, mon_e.ovr, mon_e.ovr});
`ifdef TDM_DEMUX_PARITY_EN
                check_val("pub_perr",  32'({pe0, pe1}), {30'h0, mon_e.perr, mon_e.perr});
`endif
                $display("frame %0d: dout0=%h dout1=%h fv=%b ovr=%b (exp %h/%h ovr=%b)",
                         frame_no, dout0, dout1, fv0, ov0, mon_e.d0, mon_e.d1, mon_e.ovr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset(2);
        check_reset_state("reset");

        // Basic frame, LSB first on dut0 and MSB first on dut1
        send_frame(16'hA5C3, 1'b0, 1'b0, 0, 1'b0);
        check_val("a5c3_slot_wrap", 32'(sc0), 32'h0);
        idle(1);
        check_val("a5c3_done_one_cycle", 32'(fd0), 32'h0);
        check_val("a5c3_fv_held", 32'(fv0), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("ack_clears_fv", 32'({fv0, fv1}), 32'h0);
        check_val("ack_dout_held", 32'(dout0), 32'hA5C3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("ack_idle_fv", 32'(fv0), 32'h0);
        check_val("ack_idle_ovr", 32'(ov0), 32'h0);

        // Partial frame abandoned by sof with a valid bit
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom % 2), 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("partial_slot5", 32'(sc0), 32'h5);
        send_frame(16'h1234, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // sof without a valid bit only rewinds the counter
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("sof_novalid_slot", 32'(sc0), 32'h0);
        send_frame(16'h0F0F, 1'b0, 1'b1, 0, 1'b0);

        // Back-to-back frames with no ack: overrun
        do_reset(1);
        send_frame(16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
        send_frame(16'h0001, 1'b0, 1'b0, 0, 1'b0);
        check_val("b2b_overrun", 32'(ov0), 32'h1);
        check_val("b2b_dout", 32'(dout0), 32'h0001);

        // Same, with ack on the second publish cycle: publish wins, no overrun
        do_reset(1);
        send_frame(16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
        send_frame(16'h0001, 1'b0, 1'b1, 0, 1'b0);
        check_val("ack_pub_ovr", 32'(ov0), 32'h0);
        check_val("ack_pub_fv", 32'(fv0), 32'h1);

        // Gapped bits, reset pulled at slot 8
        do_reset(1);
        cur_word = 16'h5A5A;
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(3, 0));
            cyc(1'b1, cur_word[i], 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_val("gap_slot8", 32'(sc0), 32'h8);
        do_reset(1);
        check_reset_state("midreset");
        send_frame(16'h00FF, 1'b0, 1'b0, 3, 1'b0);
        send_frame(16'h3C96, 1'b0, 1'b1, 3, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
        // Parity: good then bad parity bit
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0007, 1'b0, 1'b0, 0, 1'b0);
        check_val("par_good", 32'(pe0), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0007, 1'b0, 1'b0, 0, 1'b1);
        check_val("par_bad", 32'(pe0), 32'h1);
        check_val("par_bad_dout", 32'(dout0), 32'h0007);
`endif

        idle(3);
        check_val("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
